// File: rtl/approx_adder_arbiter.sv
// Round-robin arbiter in front of one shared SIZE-bit approximate ripple-carry adder, with a one-entry result buffer.
// An approximated bit computes sum=a^b and carry=a&b and ignores its carry-in. APPROX_LVL_CLAMP_EN limits the level to MAX_APPROX.
module approx_adder_arbiter #(
  parameter int SIZE       = 8,
  parameter int NREQ       = 4,
  parameter int LVLW       = $clog2(SIZE+1),
  parameter int MAX_APPROX = SIZE/2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*SIZE-1:0]     req_a,
  input  logic [NREQ*SIZE-1:0]     req_b,
  input  logic [NREQ-1:0]          req_cin,
  input  logic [NREQ*LVLW-1:0]     req_lvl,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [SIZE:0]            res_sum,
  output logic                     res_cout,
  output logic [$clog2(NREQ)-1:0]  res_id,
  output logic [LVLW-1:0]          res_lvl
);

  localparam int IDW = $clog2(NREQ);
`ifdef APPROX_LVL_CLAMP_EN
  localparam logic [LVLW-1:0] LVL_LIM = LVLW'((MAX_APPROX < SIZE) ? MAX_APPROX : SIZE);
`else
  localparam logic [LVLW-1:0] LVL_LIM = LVLW'(SIZE);
`endif

  logic             res_valid_r;
  logic [SIZE:0]    res_sum_r;
  logic             res_cout_r;
  logic [IDW-1:0]   res_id_r;
  logic [LVLW-1:0]  res_lvl_r;
  logic [IDW-1:0]   rr_ptr_r;

  logic             can_accept_s;
  logic             gnt_found_s;
  logic [IDW-1:0]   gnt_idx_s;
  logic [NREQ-1:0]  req_ready_s;
  logic             xfer_s;
  logic [SIZE-1:0]  op_a_s;
  logic [SIZE-1:0]  op_b_s;
  logic             op_cin_s;
  logic [LVLW-1:0]  lvl_raw_s;
  logic [LVLW-1:0]  lvl_eff_s;
  logic [SIZE-1:0]  approx_en_s;
  logic [SIZE:0]    carry_s;
  logic [SIZE:0]    sum_s;

  // Round-robin search starting at rr_ptr, one-hot grant only when the buffer can take a result
  always_comb begin
    can_accept_s = !res_valid_r || res_ready;
    gnt_found_s  = 1'b0;
    gnt_idx_s    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_found_s && req_valid[(int'(rr_ptr_r) + i) % NREQ]) begin
        gnt_found_s = 1'b1;
        gnt_idx_s   = IDW'((int'(rr_ptr_r) + i) % NREQ);
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
    if (rst || !can_accept_s || !gnt_found_s) begin
      req_ready_s = '0;
    end else begin
      req_ready_s = {{(NREQ-1){1'b0}}, 1'b1} << gnt_idx_s;
    end
  end

  assign req_ready = req_ready_s;
  assign xfer_s    = |(req_valid & req_ready_s);

  // Granted operand mux, level saturation and the approximate ripple-carry chain
  always_comb begin
    op_a_s    = req_a[int'(gnt_idx_s)*SIZE +: SIZE];
    op_b_s    = req_b[int'(gnt_idx_s)*SIZE +: SIZE];
    op_cin_s  = req_cin[gnt_idx_s];
    lvl_raw_s = req_lvl[int'(gnt_idx_s)*LVLW +: LVLW];
    if (lvl_raw_s > LVL_LIM) begin
      lvl_eff_s = LVL_LIM;
    end else begin
      lvl_eff_s = lvl_raw_s;
    end
    carry_s    = '0;
    sum_s      = '0;
    carry_s[0] = op_cin_s;
    for (int i = 0; i < SIZE; i++) begin
      approx_en_s[i] = (int'(lvl_eff_s) > i);
      if (approx_en_s[i]) begin
        sum_s[i]     = op_a_s[i] ^ op_b_s[i];
        carry_s[i+1] = op_a_s[i] & op_b_s[i];
      end else begin
        sum_s[i]     = op_a_s[i] ^ op_b_s[i] ^ carry_s[i];
        carry_s[i+1] = (op_a_s[i] & op_b_s[i]) | (carry_s[i] & (op_a_s[i] ^ op_b_s[i]));
      end
    end
    // Sign bit of sext(a)+sext(b): the extension bits repeat the MSBs and absorb the MSB carry-out
    sum_s[SIZE] = op_a_s[SIZE-1] ^ op_b_s[SIZE-1] ^ carry_s[SIZE];
  end

  // Result buffer and round-robin pointer; a drain and a new load may share one edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_r <= 1'b0;
      res_sum_r   <= '0;
      res_cout_r  <= 1'b0;
      res_id_r    <= '0;
      res_lvl_r   <= '0;
      rr_ptr_r    <= '0;
    end else if (xfer_s) begin
      res_valid_r <= 1'b1;
      res_sum_r   <= sum_s;
      res_cout_r  <= carry_s[SIZE];
      res_id_r    <= gnt_idx_s;
      res_lvl_r   <= lvl_eff_s;
      rr_ptr_r    <= (gnt_idx_s == IDW'(NREQ-1)) ? '0 : gnt_idx_s + IDW'(1);
    end else if (res_ready) begin
      res_valid_r <= 1'b0;
    end else begin
      res_valid_r <= res_valid_r;
    end
  end

  assign res_valid = res_valid_r;
  assign res_sum   = res_sum_r;
  assign res_cout  = res_cout_r;
  assign res_id    = res_id_r;
  assign res_lvl   = res_lvl_r;

endmodule

// File: tb/tb_approx_adder_arbiter.sv
// Self-checking bench for approx_adder_arbiter: directed scenarios plus randomized traffic against an arithmetic reference model.
module tb_approx_adder_arbiter;
  localparam int SIZE = 8;
  localparam int NREQ = 4;
  localparam int LVLW = 4;
  localparam int IDW  = 2;
  localparam int MAX_APPROX = SIZE/2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*SIZE-1:0] req_a;
  logic [NREQ*SIZE-1:0] req_b;
  logic [NREQ-1:0]      req_cin;
  logic [NREQ*LVLW-1:0] req_lvl;
  logic                 res_valid;
  logic                 res_ready = 1'b0;
  logic [SIZE:0]        res_sum;
  logic                 res_cout;
  logic [IDW-1:0]       res_id;
  logic [LVLW-1:0]      res_lvl;

  logic [SIZE-1:0] da [NREQ];
  logic [SIZE-1:0] db [NREQ];
  logic            dcin [NREQ];
  logic [LVLW-1:0] dlvl [NREQ];

  // reference model state
  logic            m_valid;
  logic [SIZE:0]   m_sum;
  logic            m_cout;
  logic [IDW-1:0]  m_id;
  logic [LVLW-1:0] m_lvl;
  int              m_rr;

  int vectors = 0;
  int miscompares = 0;

  approx_adder_arbiter #(.SIZE(SIZE), .NREQ(NREQ), .LVLW(LVLW), .MAX_APPROX(MAX_APPROX)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_lvl(req_lvl),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
    .res_cout(res_cout), .res_id(res_id), .res_lvl(res_lvl)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*SIZE +: SIZE] = da[i];
      req_b[i*SIZE +: SIZE] = db[i];
      req_cin[i]            = dcin[i];
      req_lvl[i*LVLW +: LVLW] = dlvl[i];
    end
  end

  function automatic int eff_lvl(input logic [LVLW-1:0] l);
    int lim;
`ifdef APPROX_LVL_CLAMP_EN
    lim = MAX_APPROX;
`else
    lim = SIZE;
`endif
    return (int'(l) > lim) ? lim : int'(l);
  endfunction

  // Low k bits are carry-free XOR; the upper part is plain integer addition fed by a[k-1]&b[k-1]
  function automatic logic [SIZE+1:0] ref_add(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                                              input logic cin, input int k);
    int sa, sb, ua, ub, low, ck, hi, uh, full;
    logic [SIZE:0] s;
    logic c;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ua = int'(a);
    ub = int'(b);
    low = int'(a ^ b) & ((1 << k) - 1);
    ck = (k == 0) ? int'(cin) : int'(a[k-1] & b[k-1]);
    hi = (sa >>> k) + (sb >>> k) + ck;
    full = (hi <<< k) | low;
    uh = (ua >> k) + (ub >> k) + ck;
    c = 1'(((uh >> (SIZE - k)) & 1));
    s = full[SIZE:0];
    return {c, s};
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_sum = '0; m_cout = 1'b0; m_id = '0; m_lvl = '0; m_rr = 0;
  endtask

  // Drive one cycle of handshakes, advance the model across the edge, and hand back the grant seen/expected
  task automatic step(input logic [NREQ-1:0] v, input logic rdy,
                      output logic [NREQ-1:0] exp_rdy, output logic [NREQ-1:0] act_rdy);
    int g;
    logic [SIZE+1:0] r;
    req_valid = v;
    res_ready = rdy;
    #1;
    act_rdy = req_ready;
    exp_rdy = '0;
    g = -1;
    if (!m_valid || rdy) begin
      for (int i = 0; i < NREQ; i++) begin
        if (g < 0 && v[(m_rr + i) % NREQ]) g = (m_rr + i) % NREQ;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    @(posedge clk);
    if (g >= 0) begin
      r = ref_add(da[g], db[g], dcin[g], eff_lvl(dlvl[g]));
      m_sum = r[SIZE:0];
      m_cout = r[SIZE+1];
      m_id = IDW'(g);
      m_lvl = LVLW'(eff_lvl(dlvl[g]));
      m_valid = 1'b1;
      m_rr = (g + 1) % NREQ;
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < NREQ; i++) begin
      da[i] = SIZE'(i + 1); db[i] = SIZE'(i); dcin[i] = 1'b0; dlvl[i] = '0;
    end
    req_valid = '1;
    res_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if ({res_valid, res_sum, res_cout, res_id, res_lvl, req_ready} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got valid=%b sum=%h cout=%b id=%0d lvl=%0d ready=%b, need all zero",
               res_valid, res_sum, res_cout, res_id, res_lvl, req_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_rotation();
    logic [NREQ-1:0] e, a;
    int seq [5] = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 1'b1, e, a);
      vectors++;
      if (a !== e || res_valid !== 1'b1 || int'(res_id) != seq[i]) begin
        miscompares++;
        $display("FAIL rotation[%0d]: got ready=%b valid=%b id=%0d, need ready=%b valid=1 id=%0d",
                 i, a, res_valid, res_id, e, seq[i]);
      end
    end
  endtask

  task automatic test_exact();
    logic [NREQ-1:0] e, a;
    da[2] = 8'h80; db[2] = 8'hFF; dcin[2] = 1'b0; dlvl[2] = 4'd0;
    step(4'b0100, 1'b1, e, a);
    vectors++;
    if (a !== 4'b0100 || res_sum !== 9'h17F || res_cout !== 1'b1 || res_id !== 2'd2 || res_lvl !== 4'd0) begin
      miscompares++;
      $display("FAIL exact_add: got ready=%b sum=%h cout=%b id=%0d lvl=%0d, need ready=0100 sum=17f cout=1 id=2 lvl=0",
               a, res_sum, res_cout, res_id, res_lvl);
    end
  endtask

  task automatic test_backpressure();
    logic [NREQ-1:0] e, a;
    logic [SIZE:0] s_sum;
    logic s_cout;
    logic [IDW-1:0] s_id;
    logic [LVLW-1:0] s_lvl;
    da[0] = 8'h35; db[0] = 8'hC4; dcin[0] = 1'b1; dlvl[0] = 4'd2;
    da[1] = 8'h7F; db[1] = 8'h01; dcin[1] = 1'b0; dlvl[1] = 4'd0;
    step(4'b0001, 1'b1, e, a);
    s_sum = res_sum; s_cout = res_cout; s_id = res_id; s_lvl = res_lvl;
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 1'b0, e, a);
      vectors++;
      if (a !== 4'b0000 || res_valid !== 1'b1 || res_sum !== s_sum || res_cout !== s_cout ||
          res_id !== s_id || res_lvl !== s_lvl) begin
        miscompares++;
        $display("FAIL hold[%0d]: got ready=%b valid=%b sum=%h id=%0d, need ready=0000 valid=1 sum=%h id=%0d",
                 i, a, res_valid, res_sum, res_id, s_sum, s_id);
      end
    end
    step(4'b0010, 1'b1, e, a);
    vectors++;
    if (a !== 4'b0010 || res_valid !== 1'b1 || res_id !== 2'd1 || res_sum !== 9'h080 || res_cout !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_load: got ready=%b valid=%b id=%0d sum=%h cout=%b, need ready=0010 valid=1 id=1 sum=080 cout=0",
               a, res_valid, res_id, res_sum, res_cout);
    end
  endtask

  task automatic test_approx();
    logic [NREQ-1:0] e, a;
    da[0] = 8'h0F; db[0] = 8'h01; dcin[0] = 1'b0; dlvl[0] = 4'd3;
    step(4'b0001, 1'b1, e, a);
    vectors++;
    if (res_sum !== 9'h00E || res_lvl !== 4'd3 || res_cout !== 1'b0 || res_sum !== m_sum) begin
      miscompares++;
      $display("FAIL approx_lvl3: got sum=%h lvl=%0d cout=%b, need sum=00e lvl=3 cout=0", res_sum, res_lvl, res_cout);
    end
    dlvl[0] = 4'd7;
    step(4'b0001, 1'b1, e, a);
    vectors++;
`ifdef APPROX_LVL_CLAMP_EN
    if (res_lvl !== 4'd4 || res_sum !== 9'h00E) begin
`else
    if (res_lvl !== 4'd7 || res_sum !== 9'h00E) begin
`endif
      miscompares++;
      $display("FAIL approx_lvl7: got lvl=%0d sum=%h, need lvl=%0d sum=00e", res_lvl, res_sum, m_lvl);
    end
    da[0] = 8'hFF; dlvl[0] = 4'd15;
    step(4'b0001, 1'b1, e, a);
    vectors++;
`ifdef APPROX_LVL_CLAMP_EN
    if (res_lvl !== 4'd4 || res_sum !== 9'h1FE || res_cout !== 1'b0) begin
`else
    if (res_lvl !== 4'd8 || res_sum !== 9'h1FE || res_cout !== 1'b0) begin
`endif
      miscompares++;
      $display("FAIL approx_sat: got lvl=%0d sum=%h cout=%b, need lvl=%0d sum=1fe cout=0",
               res_lvl, res_sum, res_cout, m_lvl);
    end
  endtask

  task automatic test_reset_midop();
    logic [NREQ-1:0] e, a;
    for (int i = 0; i < NREQ; i++) dlvl[i] = 4'd0;
    step(4'b1000, 1'b1, e, a);
    req_valid = 4'b1111;
    res_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (res_valid !== 1'b0 || req_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL async_reset: got valid=%b ready=%b, need valid=0 ready=0000", res_valid, req_ready);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(4'b0110, 1'b1, e, a);
    vectors++;
    if (a !== 4'b0010 || res_id !== 2'd1 || res_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_grant: got ready=%b id=%0d valid=%b, need ready=0010 id=1 valid=1", a, res_id, res_valid);
    end
  endtask

  task automatic test_random();
    logic [NREQ-1:0] e, a;
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        da[i] = SIZE'($urandom); db[i] = SIZE'($urandom);
        dcin[i] = 1'($urandom); dlvl[i] = LVLW'($urandom_range(0, 15));
      end
      step(NREQ'($urandom), 1'($urandom_range(0, 3) != 0), e, a);
      vectors++;
      if (a !== e || {res_valid, res_sum, res_cout, res_id, res_lvl} !== {m_valid, m_sum, m_cout, m_id, m_lvl}) begin
        miscompares++;
        $display("FAIL random[%0d]: got ready=%b v=%b sum=%h c=%b id=%0d lvl=%0d, need ready=%b v=%b sum=%h c=%b id=%0d lvl=%0d",
                 n, a, res_valid, res_sum, res_cout, res_id, res_lvl, e, m_valid, m_sum, m_cout, m_id, m_lvl);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_exact();
    test_backpressure();
    test_approx();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
